// File: rtl/pipeline_arbiter_pkg.sv
// rtl/pipeline_arbiter_pkg.sv - shared helpers and types for pipeline_arbiter
package pipeline_arbiter_pkg;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ID_W    = id_w(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_WIDTH-1:0] payload;
    } pkt_t;

    typedef enum logic {
        LOCK_OPEN = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

endpackage

// File: rtl/pipeline_arbiter_rr_arbiter.sv
// rtl/pipeline_arbiter_rr_arbiter.sv - combinational round-robin grant from a start pointer
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int k;
        k     = 0;
        grant = '0;
        idx   = ptr;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any && req[k]) begin
                any = 1'b1;
                idx = IDX_W'(k);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_arbiter.sv
// rtl/pipeline_arbiter.sv - round-robin share of one tagged valid/ready pipeline with in-flight cap
module pipeline_arbiter
    import pipeline_arbiter_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  WIDTH        = 8,
    parameter int  MAX_INFLIGHT = 8,
    localparam int ID_W         = id_w(NUM_REQ),
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [ID_W+WIDTH-1:0]    pipe_data_o,
    output logic                     pipe_valid_o,
    input  logic                     pipe_ready_i,
    input  logic [ID_W+WIDTH-1:0]    pipe_data_i,
    input  logic                     pipe_valid_i,
    output logic                     pipe_ready_o,
    output logic [WIDTH-1:0]         rsp_data_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [CNT_W-1:0]         inflight_o,
    output logic                     err_o
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] payload;
    } pkt_w_t;

    lock_state_e       lock_q, lock_d;
    logic [ID_W-1:0]   locked_id_q, locked_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [ID_W-1:0]    g;
    logic [NUM_REQ-1:0] sel_onehot;
    logic               sel_valid;
    logic               can_issue;
    logic               issue_hs;
    logic               ret_hs;
    logic               ret_id_ok;
    pkt_w_t             issue_pkt;
    pkt_w_t             ret_pkt;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid_i),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Registered count only: a same-cycle return never frees a slot for issue.
    assign can_issue = (inflight_q < CNT_W'(MAX_INFLIGHT));

    always_comb begin
        sel_onehot = '0;
        if (lock_q == LOCK_HELD) begin
            g                       = locked_id_q;
            sel_valid               = req_valid_i[locked_id_q];
            sel_onehot[locked_id_q] = 1'b1;
        end else begin
            g          = arb_idx;
            sel_valid  = arb_any;
            sel_onehot = arb_grant;
        end
        issue_pkt.id      = g;
        issue_pkt.payload = req_data_i[int'(g)*WIDTH +: WIDTH];
        pipe_data_o       = issue_pkt;
        pipe_valid_o      = can_issue && sel_valid && !rst_i;
        req_ready_o       = (can_issue && pipe_ready_i && !rst_i) ? sel_onehot : '0;
        issue_hs          = pipe_valid_o && pipe_ready_i;
    end

    always_comb begin
        ret_pkt      = pipe_data_i;
        ret_id_ok    = (int'(ret_pkt.id) < NUM_REQ);
        rsp_data_o   = ret_pkt.payload;
        rsp_valid_o  = '0;
        pipe_ready_o = 1'b0;
        if (!rst_i) begin
            if (ret_id_ok) begin
                rsp_valid_o[ret_pkt.id] = pipe_valid_i;
                pipe_ready_o            = rsp_ready_i[ret_pkt.id];
            end else begin
                pipe_ready_o = 1'b1;
            end
        end
        ret_hs = pipe_valid_i && pipe_ready_o;
    end

    always_comb begin
        lock_d      = LOCK_OPEN;
        locked_id_d = locked_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (issue_hs) begin
            rr_ptr_d = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        end else if (pipe_valid_o) begin
            lock_d      = LOCK_HELD;
            locked_id_d = g;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (issue_hs && !ret_hs) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue_hs && ret_hs && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end
        if (ret_hs && (!ret_id_ok || (inflight_q == '0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q      <= LOCK_OPEN;
            locked_id_q <= '0;
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

    assign inflight_o = inflight_q;
    assign err_o      = err_q;

    // A requester holding the pipeline must keep its valid up until accepted.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (lock_q == LOCK_HELD) |-> req_valid_i[locked_id_q]);

endmodule

// File: tb/tb_pipeline_arbiter.sv
// tb/tb_pipeline_arbiter.sv - directed and randomized checks of pipeline_arbiter against a queue model
module tb_pipeline_arbiter;

    localparam int NR = 4, W = 8, MAXI = 8, IDW = 2, STG = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_valid, req_ready;
    logic [IDW+W-1:0]  p_in_data, p_out_data;
    logic              p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [W-1:0]      rsp_data;
    logic [NR-1:0]     rsp_valid, rsp_ready;
    logic [3:0]        inflight;
    logic              err;
    logic              hold_in;

    pipeline_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_INFLIGHT(MAXI)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .pipe_data_o(p_in_data), .pipe_valid_o(p_in_valid), .pipe_ready_i(p_in_ready),
        .pipe_data_i(p_out_data), .pipe_valid_i(p_out_valid), .pipe_ready_o(p_out_ready),
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .inflight_o(inflight), .err_o(err)
    );

    logic              r3_rst;
    logic [3*W-1:0]    r3_req_data;
    logic [2:0]        r3_req_valid, r3_req_ready, r3_rsp_valid, r3_rsp_ready;
    logic [IDW+W-1:0]  r3_p_in_data, r3_p_out_data;
    logic              r3_p_in_valid, r3_p_in_ready, r3_p_out_valid, r3_p_out_ready, r3_err;
    logic [W-1:0]      r3_rsp_data;
    logic [3:0]        r3_inflight;

    pipeline_arbiter #(.NUM_REQ(3), .WIDTH(W), .MAX_INFLIGHT(MAXI)) dut3 (
        .clk_i(clk), .rst_i(r3_rst),
        .req_data_i(r3_req_data), .req_valid_i(r3_req_valid), .req_ready_o(r3_req_ready),
        .pipe_data_o(r3_p_in_data), .pipe_valid_o(r3_p_in_valid), .pipe_ready_i(r3_p_in_ready),
        .pipe_data_i(r3_p_out_data), .pipe_valid_i(r3_p_out_valid), .pipe_ready_o(r3_p_out_ready),
        .rsp_data_o(r3_rsp_data), .rsp_valid_o(r3_rsp_valid), .rsp_ready_i(r3_rsp_ready),
        .inflight_o(r3_inflight), .err_o(r3_err)
    );

    // Fixed-latency pipeline with a global stall when its head is not taken.
    logic [IDW+W-1:0] st_d [STG];
    logic [STG-1:0]   st_v;
    logic             advance;
    assign advance     = !(st_v[STG-1] && !p_out_ready);
    assign p_in_ready  = advance && !hold_in;
    assign p_out_valid = st_v[STG-1];
    assign p_out_data  = st_d[STG-1];

    always @(posedge clk) begin
        if (rst) begin
            st_v <= '0;
        end else if (advance) begin
            st_v     <= {st_v[STG-2:0], p_in_valid && p_in_ready};
            st_d[0]  <= p_in_data;
            for (int i = 1; i < STG; i++) st_d[i] <= st_d[i-1];
        end
    end

    int n_tests = 0, n_fail = 0;
    bit pend [NR];
    logic [W-1:0] pay [NR];
    logic [W-1:0] exp_q [NR][$];
    bit rq_en [NR];
    int rq_pct;
    bit fixed_pay, rnd;
    int m_ptr, m_lock_id, m_inflight;
    bit m_locked;
    bit saw_issue, saw_ret;
    int obs_id, issue_cnt, c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_req();
        for (int k = 0; k < NR; k++) begin
            req_valid[k]       = pend[k];
            req_data[k*W +: W] = pay[k];
        end
    endtask

    function automatic bit any_pend();
        bit a = 0;
        for (int k = 0; k < NR; k++) a |= pend[k];
        return a;
    endfunction

    task automatic tick();
        int g, rid;
        bit can, any, exp_pv, issue, ret;
        logic [NR-1:0] exp_rv;
        #3;
        can = (m_inflight < MAXI);
        any = m_locked;
        g   = m_lock_id;
        if (!m_locked) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (m_ptr + i) % NR;
                if (!any && pend[k]) begin any = 1; g = k; end
            end
        end
        exp_pv = can && any && pend[g];
        chk("pipe_valid", p_in_valid, exp_pv);
        if (any) chk("req_ready", req_ready, (can && p_in_ready) ? (1 << g) : 0);
        else     chk("req_ready_idle", req_ready & req_valid, 0);
        if (exp_pv) chk("pipe_data", p_in_data, {IDW'(g), pay[g]});
        chk("inflight", inflight, m_inflight);
        chk("inflight_cap", inflight <= MAXI, 1);
        saw_issue = p_in_valid && p_in_ready;
        if (saw_issue) begin obs_id = int'(p_in_data[W +: IDW]); issue_cnt++; end
        rid    = int'(p_out_data[W +: IDW]);
        exp_rv = p_out_valid ? NR'(1 << rid) : '0;
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("pipe_ready_o", p_out_ready, rsp_ready[rid]);
        ret     = p_out_valid && rsp_ready[rid];
        saw_ret = ret;
        if (ret) begin
            chk("rsp_outstanding", exp_q[rid].size() != 0, 1);
            if (exp_q[rid].size() != 0) chk("rsp_data", rsp_data, exp_q[rid].pop_front());
        end
        issue = exp_pv && p_in_ready;
        m_inflight += int'(issue) - int'(ret);
        if (issue) begin
            exp_q[g].push_back(pay[g]);
            pend[g]  = 0;
            m_ptr    = (g + 1) % NR;
            m_locked = 0;
        end else if (exp_pv) begin
            m_locked  = 1;
            m_lock_id = g;
        end else begin
            m_locked = 0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < NR; k++) begin
            if (!pend[k] && rq_en[k] && ($urandom_range(99) < rq_pct)) begin
                pend[k] = 1;
                pay[k]  = fixed_pay ? W'(8'hA0 + k) : W'($urandom);
            end
        end
        if (rnd) begin
            rsp_ready = NR'($urandom);
            hold_in   = ($urandom_range(3) == 0);
        end
        drive_req();
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        for (int i = 0; i < n; i++) begin
            #3;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_pipe_valid", p_in_valid, 0);
            chk("rst_pipe_ready", p_out_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            @(posedge clk); #1;
        end
        rst        = 0;
        m_ptr      = 0;
        m_locked   = 0;
        m_lock_id  = 0;
        m_inflight = 0;
        for (int k = 0; k < NR; k++) begin pend[k] = 0; exp_q[k].delete(); end
        drive_req();
        #1;
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic drain();
        rnd = 0; hold_in = 0; rsp_ready = '1;
        for (int k = 0; k < NR; k++) rq_en[k] = 0;
        for (int t = 0; t < 200; t++) begin
            if (inflight == 0 && !any_pend()) break;
            tick();
        end
        chk("drain_done", inflight, 0);
    endtask

    initial begin
        rst = 1; hold_in = 0; rsp_ready = '1; rq_pct = 100; fixed_pay = 1; rnd = 0;
        issue_cnt = 0; obs_id = 0; saw_issue = 0; saw_ret = 0;
        for (int k = 0; k < NR; k++) begin rq_en[k] = 0; pend[k] = 0; pay[k] = '0; end
        drive_req();
        r3_rst = 1; r3_req_data = '0; r3_req_valid = '0; r3_p_in_ready = 1;
        r3_p_out_data = '0; r3_p_out_valid = 0; r3_rsp_ready = '0;
        @(posedge clk); #1;
        do_reset(2);
        r3_rst = 0;

        // 1: all requesters busy, fixed payloads, strict rotation from requester 0
        for (int k = 0; k < NR; k++) begin rq_en[k] = 1; pend[k] = 1; pay[k] = W'(8'hA0 + k); end
        drive_req();
        #1;
        chk("t1_first_data", p_in_data, 10'h0A0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_issue_each_cycle", saw_issue, 1);
            chk("t1_order", obs_id, i % NR);
        end
        for (int i = 0; i < 30; i++) tick();
        drain();

        // 2: only requester 2; first issue moves the pointer to 3, then wrap back to 2
        fixed_pay = 0; rq_en[2] = 1; pend[2] = 1; pay[2] = W'($urandom); drive_req();
        c = issue_cnt;
        for (int t = 0; t < 40 && (issue_cnt - c) < 11; t++) begin
            tick();
            if (t < 8) chk("t2_back_to_back", saw_issue, 1);
            if (saw_issue) chk("t2_grant", obs_id, 2);
        end
        chk("t2_count", issue_cnt - c, 11);
        drain();

        // 3: lock on stalled pipeline input, pointer lands after the locked requester
        pend[3] = 1; pay[3] = W'($urandom); drive_req();
        saw_issue = 0;
        for (int t = 0; t < 20 && !saw_issue; t++) tick();
        chk("t3_pre_grant", obs_id, 3);
        hold_in = 1; pend[1] = 1; pay[1] = 8'h5C; drive_req();
        tick(); tick();
        pend[0] = 1; pay[0] = 8'h3E; drive_req();
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("t3_locked_data", p_in_data, {2'd1, 8'h5C});
        end
        hold_in = 0; pend[2] = 1; pay[2] = 8'h77; drive_req();
        tick();
        chk("t3_accept", saw_issue, 1);
        chk("t3_accept_id", obs_id, 1);
        tick();
        chk("t3_after_ptr", obs_id, 2);
        tick();
        chk("t3_then_req0", obs_id, 0);
        drain();

        // 4: no result consumer, cap holds at MAX_INFLIGHT, then release requester 0
        rsp_ready = '0; rq_en[0] = 1; pend[0] = 1; pay[0] = W'($urandom); drive_req();
        c = issue_cnt;
        for (int i = 0; i < 20; i++) tick();
        chk("t4_issues", issue_cnt - c, 8);
        chk("t4_inflight_full", inflight, 8);
        chk("t4_no_issue", p_in_valid, 0);
        rsp_ready = 4'b0001;
        for (int i = 0; i < 40; i++) tick();
        chk("t4_resumed", (issue_cnt - c) > 8, 1);
        drain();

        // 5: same-cycle issue and return at 5 in flight
        rsp_ready = '0; rq_en[0] = 1; pend[0] = 1; pay[0] = W'($urandom); drive_req();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) rq_en[0] = 0;
            tick();
        end
        for (int i = 0; i < 6; i++) tick();
        chk("t5_at_five", inflight, 5);
        chk("t5_head_waiting", p_out_valid, 1);
        pend[0] = 1; pay[0] = W'($urandom); rsp_ready = 4'b0001; drive_req();
        tick();
        chk("t5_issue", saw_issue, 1);
        chk("t5_ret", saw_ret, 1);
        chk("t5_unchanged", inflight, 5);
        drain();

        // randomized traffic with a reset in the middle
        rnd = 1; rq_pct = 60;
        for (int k = 0; k < NR; k++) rq_en[k] = 1;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                do_reset(1);
                rq_pct = 85;
            end
            tick();
        end
        drain();

        // 6: out-of-range ID on a 3-requester instance
        r3_p_out_valid = 1; r3_p_out_data = {2'd3, 8'h55}; r3_rsp_ready = '0;
        #1;
        chk("t6_drop_ready", r3_p_out_ready, 1);
        chk("t6_no_rsp", r3_rsp_valid, 0);
        chk("t6_err_before", r3_err, 0);
        @(posedge clk); #1;
        r3_p_out_valid = 0;
        #1;
        chk("t6_err_set", r3_err, 1);
        chk("t6_inflight", r3_inflight, 0);
        r3_p_out_valid = 1; r3_p_out_data = {2'd1, 8'h66}; r3_rsp_ready = 3'b101;
        #1;
        chk("t6_route_valid", r3_rsp_valid, 3'b010);
        chk("t6_route_ready", r3_p_out_ready, 0);
        chk("t6_route_data", r3_rsp_data, 8'h66);
        r3_p_out_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_err_sticky", r3_err, 1);
        r3_rst = 1;
        #1;
        chk("t6_rst_ready", r3_p_out_ready, 0);
        @(posedge clk); #1;
        r3_rst = 0;
        #1;
        chk("t6_err_cleared", r3_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
